// File: rtl/nz_scheduler_6_pkg.sv
// Shared types and helpers for the nonzero scheduler.
// Holds the state encoding and the log2 helper used for index widths.
package nz_scheduler_6_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int NUM_W = 3;

  function automatic int c_log_2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/nz_scheduler_6_pick6.sv
// Combinational pick of the lowest up to MAC_DIM set mask bits.
// Returns ascending indices, count-1 and the mask with them cleared.
module nz_pick6
  import nz_scheduler_6_pkg::*;
#(
  parameter int MAC_DIM    = 6,
  parameter int SPAD_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic [SPAD_WIDTH-1:0]                mask,
  output logic [MAC_DIM-1:0][ADDR_WIDTH-1:0]   idx,
  output logic [NUM_W-1:0]                     num,
  output logic [SPAD_WIDTH-1:0]                rest
);

  logic [SPAD_WIDTH-1:0] m;
  logic [ADDR_WIDTH-1:0] pos;
  logic                  found;
  int                    n;

  // Repeated lowest-set-bit search; unused slots stay zero.
  always_comb begin
    m     = mask;
    idx   = '0;
    n     = 0;
    pos   = '0;
    found = 1'b0;
    for (int j = 0; j < MAC_DIM; j++) begin
      found = 1'b0;
      pos   = '0;
      for (int i = SPAD_WIDTH - 1; i >= 0; i--) begin
        if (m[i]) begin
          found = 1'b1;
          pos   = ADDR_WIDTH'(i);
        end
      end
      if (found) begin
        idx[j] = pos;
        m[pos] = 1'b0;
        n      = n + 1;
      end
    end
    rest = m;
    num  = (n == 0) ? '0 : NUM_W'(n - 1);
  end

endmodule

// File: rtl/nz_scheduler_6.sv
// Sparse feature scheduler: emits MAC address groups per beat.
// First beat is registered on the accepting edge itself.
module nz_scheduler_6
  import nz_scheduler_6_pkg::*;
#(
  parameter int MAC_DIM    = 6,
  parameter int FEAT_WIDTH = 8,
  parameter int SPAD_WIDTH = 64,
  parameter int ADDR_WIDTH = c_log_2(SPAD_WIDTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [FEAT_WIDTH*SPAD_WIDTH-1:0] feature_in,
  input  logic                            stall,
  output logic                            busy,
  output logic                            beat_vd,
  output logic [ADDR_WIDTH*MAC_DIM-1:0]   non_zero_add_out,
  output logic [NUM_W-1:0]                non_zero_num,
  output logic                            acc,
  output logic                            done
);

  state_t                             state, state_n;
  logic [SPAD_WIDTH-1:0]              nz, mask, pick_in, rest;
  logic [MAC_DIM-1:0][ADDR_WIDTH-1:0] idx;
  logic [NUM_W-1:0]                   num;
  logic                               accept, emit;

  // Per-element nonzero detect and pick source select.
  always_comb begin
    nz = '0;
    for (int i = 0; i < SPAD_WIDTH; i++)
      nz[i] = |feature_in[i*FEAT_WIDTH +: FEAT_WIDTH];
    pick_in = (state == IDLE) ? nz : mask;
  end

  nz_pick6 #(
    .MAC_DIM   (MAC_DIM),
    .SPAD_WIDTH(SPAD_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pick (
    .mask(pick_in),
    .idx (idx),
    .num (num),
    .rest(rest)
  );

  // Next state: an empty mask in SCAN means the done beat is showing.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    emit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stall) begin
          accept  = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (!stall) begin
          if (mask == '0) state_n = IDLE;
          else            emit    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Registered beat outputs and remaining mask; all frozen by stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask             <= '0;
      beat_vd          <= 1'b0;
      acc              <= 1'b0;
      done             <= 1'b0;
      non_zero_num     <= '0;
      non_zero_add_out <= '0;
    end else if (!stall) begin
      beat_vd          <= accept | emit;
      acc              <= emit;
      done             <= (accept | emit) && (rest == '0);
      non_zero_num     <= (accept | emit) ? num : '0;
      non_zero_add_out <= (accept | emit) ? idx : '0;
      if (accept | emit) mask <= rest;
    end
  end

  assign busy = (state == SCAN);

endmodule

// File: tb/tb_nz_scheduler_6.sv
// Scoreboard bench for nz_scheduler_6.
// Directed vectors push expected beats; a forked monitor checks them.
module tb_nz_scheduler_6;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [511:0] feature_in;
  logic         stall;
  logic         busy, beat_vd, acc, done;
  logic [35:0]  non_zero_add_out;
  logic [2:0]   non_zero_num;

  typedef struct packed {
    logic [35:0] addr;
    logic [2:0]  num;
    logic        acc;
    logic        done;
  } beat_t;

  beat_t q[$];
  int    passed = 0;
  int    total  = 0;
  int    beats, dones, held, busy_cyc;

  always #5 clk = ~clk;

  nz_scheduler_6 dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .feature_in      (feature_in),
    .stall           (stall),
    .busy            (busy),
    .beat_vd         (beat_vd),
    .non_zero_add_out(non_zero_add_out),
    .non_zero_num    (non_zero_num),
    .acc             (acc),
    .done            (done)
  );

  function automatic logic [35:0] pk(int a0, int a1, int a2,
                                     int a3, int a4, int a5);
    return {6'(a5), 6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  function automatic logic [511:0] mkfeat(logic [63:0] m);
    logic [511:0] f;
    f = '0;
    for (int i = 0; i < 64; i++)
      if (m[i]) f[i*8 +: 8] = (i % 2 == 1) ? 8'h80 : 8'h01;
    return f;
  endfunction

  task automatic push(logic [35:0] a, int n, bit ac, bit dn);
    beat_t b;
    b.addr = a;
    b.num  = 3'(n);
    b.acc  = ac;
    b.done = dn;
    q.push_back(b);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cmp_beat(string name, beat_t e);
    beat_t a;
    a.addr = non_zero_add_out;
    a.num  = non_zero_num;
    a.acc  = acc;
    a.done = done;
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got addr=%h num=%0d acc=%b done=%b expected addr=%h num=%0d acc=%b done=%b",
                  name, a.addr, a.num, a.acc, a.done,
                  e.addr, e.num, e.acc, e.done);
  endtask

  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (!reset && beat_vd) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_beat: got addr=%h expected none",
                   non_zero_add_out);
        end else if (stall) begin
          held++;
          cmp_beat("held_beat", q[0]);
        end else begin
          e = q.pop_front();
          beats++;
          if (done) dones++;
          cmp_beat("beat", e);
        end
      end
    end
  endtask

  task automatic clr();
    beats = 0; dones = 0; held = 0; busy_cyc = 0;
  endtask

  task automatic send(logic [63:0] m);
    @(posedge clk);
    #1 start = 1'b1;
    feature_in = mkfeat(m);
    @(posedge clk);
    #1 start = 1'b0;
    chk("first_beat_latency", 64'(beat_vd), 64'd1);
  endtask

  task automatic wait_idle(string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      #1;
      if (!busy && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  task automatic push_13();
    push(pk(0, 1, 2, 3, 4, 5), 5, 0, 0);
    push(pk(6, 7, 8, 9, 10, 11), 5, 1, 0);
    push(pk(12, 0, 0, 0, 0, 0), 0, 1, 1);
  endtask

  initial begin
    fork
      monitor();
    join_none
    reset = 1'b1; start = 1'b0; stall = 1'b0; feature_in = '0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_vd", 64'(beat_vd), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_acc", 64'(acc), 0);
    chk("rst_num", 64'(non_zero_num), 0);
    chk("rst_addr", 64'(non_zero_add_out), 0);
    reset = 1'b0;

    // indices 3, 10, 63
    clr();
    push(pk(3, 10, 63, 0, 0, 0), 2, 0, 1);
    send(64'h8000_0000_0000_0408);
    wait_idle("idle_3_10_63");
    chk("beats_3_10_63", 64'(beats), 1);

    // indices 0..12
    clr();
    push_13();
    send(64'h1FFF);
    wait_idle("idle_0_12");
    chk("beats_0_12", 64'(beats), 3);
    chk("dones_0_12", 64'(dones), 1);

    // all-zero vector
    clr();
    push(pk(0, 0, 0, 0, 0, 0), 0, 0, 1);
    send(64'h0);
    wait_idle("idle_zero");
    chk("busy_cycles_zero", 64'(busy_cyc), 1);
    chk("beats_zero", 64'(beats), 1);

    // stall for 3 cycles during beat 2
    clr();
    push_13();
    send(64'h1FFF);
    @(posedge clk);
    #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_idle("idle_stall");
    chk("held_stall", 64'(held), 3);
    chk("beats_stall", 64'(beats), 3);

    // start during beat 2 and during the done beat
    clr();
    push_13();
    send(64'h1FFF);
    @(posedge clk);
    #1 start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_idle("idle_start_busy");
    chk("beats_start_busy", 64'(beats), 3);
    chk("dones_start_busy", 64'(dones), 1);

    // asynchronous reset mid-vector
    clr();
    push_13();
    send(64'h1FFF);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 0);
    chk("arst_vd", 64'(beat_vd), 0);
    chk("arst_addr", 64'(non_zero_add_out), 0);
    chk("arst_num", 64'(non_zero_num), 0);
    chk("arst_acc_done", 64'({acc, done}), 0);
    q.delete();
    @(posedge clk);
    #2 reset = 1'b0;
    clr();
    push(pk(3, 10, 63, 0, 0, 0), 2, 0, 1);
    send(64'h8000_0000_0000_0408);
    wait_idle("idle_after_rst");
    chk("beats_after_rst", 64'(beats), 1);

    // all 64 elements nonzero
    clr();
    for (int b = 0; b < 10; b++)
      push(pk(6*b, 6*b+1, 6*b+2, 6*b+3, 6*b+4, 6*b+5), 5, b != 0, 0);
    push(pk(60, 61, 62, 63, 0, 0), 3, 1, 1);
    send(64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle("idle_full");
    chk("beats_full", 64'(beats), 11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nz_scheduler_6.md
NZ_SCHEDULER_6 -- requirements
Module: nz_scheduler_6

Interface
REQ-001 The block SHALL have parameter MAC_DIM, default 6, giving the number of MAC slots driven per beat.
REQ-002 The block SHALL have parameter FEAT_WIDTH, default 8, giving the feature element width.
REQ-003 The block SHALL have parameter SPAD_WIDTH, default 64, giving the number of elements per spad word.
REQ-004 The block SHALL have parameter ADDR_WIDTH, default C_LOG_2(SPAD_WIDTH) = 6, giving the spad index width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: a one-cycle request to schedule feature_in.
REQ-008 The block SHALL have port feature_in, input, FEAT_WIDTH*SPAD_WIDTH bits: the feature spad word; element i occupies bits [(i+1)*FEAT_WIDTH-1 : i*FEAT_WIDTH].
REQ-009 The block SHALL have port stall, input, 1 bit: while high, the block holds its state and outputs.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a vector is being scheduled.
REQ-011 The block SHALL have port beat_vd, output, 1 bit: the address group on the outputs is valid this cycle.
REQ-012 The block SHALL have port non_zero_add_out, output, ADDR_WIDTH*MAC_DIM bits: slot j occupies bits [(j+1)*ADDR_WIDTH-1 : j*ADDR_WIDTH].
REQ-013 The block SHALL have port non_zero_num, output, 3 bits: the number of valid slots minus 1 (0..5).
REQ-014 The block SHALL have port acc, output, 1 bit: the downstream MAC accumulates onto its previous sum.
REQ-015 The block SHALL have port done, output, 1 bit: marks the last beat of the vector.

Function
REQ-016 Element i SHALL be nonzero when any of its FEAT_WIDTH bits is 1.
REQ-017 On start while in IDLE and stall is low, the block SHALL register the SPAD_WIDTH-bit nonzero mask and enter SCAN.
REQ-018 The block SHALL have exactly two states, IDLE and SCAN; busy SHALL be 1 exactly while the state is SCAN.
REQ-019 In SCAN with stall low, each cycle SHALL emit one registered beat carrying the lowest up to 6 set mask indices, in ascending order in slots 0..k-1, and SHALL clear those bits from the mask.
REQ-020 Unused slots SHALL be driven 0.
REQ-021 non_zero_num SHALL equal k-1.
REQ-022 acc SHALL be 0 on the first beat of a vector and 1 on every later beat.
REQ-023 done SHALL be 1 on the beat after which the mask is empty, and the state SHALL then return to IDLE.
REQ-024 An all-zero vector SHALL produce exactly one beat: slot0 = 0, non_zero_num = 0, acc = 0, done = 1.
REQ-025 The beat count SHALL be max(1, ceil(popcount/6)); a vector with 64 nonzero elements SHALL give 11 beats.
REQ-026 The first beat SHALL be valid in the cycle after the cycle in which start is accepted.
REQ-027 Beats SHALL then be consecutive while stall is low.
REQ-028 beat_vd, done and acc SHALL be pulses of at most one cycle per beat.
REQ-029 While stall is high, every output and internal register SHALL hold its value, and a held beat SHALL NOT be counted as consumed.
REQ-030 start SHALL be ignored while busy is high or stall is high.
REQ-031 A start in the same cycle as a done beat SHALL be ignored; the next accepted start SHALL come no earlier than the following cycle, in IDLE.

Reset
REQ-032 Assertion of reset SHALL immediately force the state to IDLE, clear the mask, and drive busy, beat_vd, acc, done, non_zero_num and non_zero_add_out to 0, including in the middle of a vector.
REQ-033 The first start after reset deassertion SHALL be accepted normally.

Structure
REQ-034 The C_LOG_2 macro and the IDLE/SCAN state encodings SHALL live in the shared header log2.vh.
REQ-035 The lowest-6-set-bit selection SHALL be one combinational sub-module, nz_pick6, with inputs mask[SPAD_WIDTH-1:0] and outputs six indices, count-1 and the cleared mask.
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 Bench: nonzero elements at indices 3, 10, 63 -> one beat with addresses {3, 10, 63, 0, 0, 0}, num = 2, acc = 0, done = 1, issued in the cycle after start.
REQ-038 Bench: indices 0..12 nonzero -> beat 1 {0..5} num 5 acc 0; beat 2 {6..11} num 5 acc 1; beat 3 {12, 0, 0, 0, 0, 0} num 0 acc 1 done 1.
REQ-039 Bench: all-zero vector -> single beat with addr 0, num 0, done 1; busy high for exactly 1 cycle.
REQ-040 Bench: indices 0..12 nonzero with stall high for 3 cycles during beat 2 -> beat 2 outputs held unchanged for those 3 cycles, beat 3 follows, total 3 beats.
REQ-041 Bench: reset asserted asynchronously mid-vector (between clock edges) -> all outputs 0 before the next edge, state IDLE; a new start after reset gives correct beats.
REQ-042 Bench: start pulsed during beat 2 of a 3-beat vector -> ignored; exactly 3 beats and one done.
